// File: rtl/vae_pkg.sv
// Shared sizes, config address map and sequencer states for the forward-VAE parameter streamer.
package vae_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int N_IN       = 9;
    localparam int N_OUT      = 9;
    localparam int N_ENC_B    = 4;
    localparam int ENC_IDX_W  = $clog2(N_IN);

    localparam logic [7:0] XJ_BASE  = 8'h00;
    localparam logic [7:0] MW1_BASE = 8'h10;
    localparam logic [7:0] MW2_BASE = 8'h20;
    localparam logic [7:0] VW1_BASE = 8'h30;
    localparam logic [7:0] VW2_BASE = 8'h40;
    localparam logic [7:0] EB_BASE  = 8'h50;
    localparam logic [7:0] D0_BASE  = 8'h60;
    localparam logic [7:0] D1_BASE  = 8'h70;
    localparam logic [7:0] DB_BASE  = 8'h80;

    typedef enum logic [2:0] {IDLE, ENC, GAP, DEC, WAIT, CAP} state_t;

    function automatic logic addr_hit(input logic [7:0] addr, input logic [7:0] base, input int idx);
        return addr == (base + idx[7:0]);
    endfunction
endpackage

// File: rtl/vae_param_streamer_if.sv
// Link between the parameter streamer and top_forward_vae: beat outputs, static biases, done/a3 return.
interface vae_param_streamer_if;
    import vae_pkg::*;

    logic                        start;
    logic [DATA_WIDTH-1:0]       xj;
    logic [DATA_WIDTH-1:0]       nnl2_mean_w1j;
    logic [DATA_WIDTH-1:0]       nnl2_mean_w2j;
    logic [DATA_WIDTH-1:0]       nnl2_var_w1j;
    logic [DATA_WIDTH-1:0]       nnl2_var_w2j;
    logic [DATA_WIDTH-1:0]       nnl2_mean_b1;
    logic [DATA_WIDTH-1:0]       nnl2_mean_b2;
    logic [DATA_WIDTH-1:0]       nnl2_var_b1;
    logic [DATA_WIDTH-1:0]       nnl2_var_b2;
    logic [N_OUT*DATA_WIDTH-1:0] nnl3_w_bus;
    logic [N_OUT*DATA_WIDTH-1:0] nnl3_b_bus;
    logic                        done;
    logic [N_OUT*DATA_WIDTH-1:0] a3_bus;

    modport master (
        output start, xj, nnl2_mean_w1j, nnl2_mean_w2j, nnl2_var_w1j, nnl2_var_w2j,
        output nnl2_mean_b1, nnl2_mean_b2, nnl2_var_b1, nnl2_var_b2, nnl3_w_bus, nnl3_b_bus,
        input  done, a3_bus
    );

    modport slave (
        input  start, xj, nnl2_mean_w1j, nnl2_mean_w2j, nnl2_var_w1j, nnl2_var_w2j,
        input  nnl2_mean_b1, nnl2_mean_b2, nnl2_var_b1, nnl2_var_b2, nnl3_w_bus, nnl3_b_bus,
        output done, a3_bus
    );
endinterface

// File: rtl/vae_param_regfile.sv
// Parameter table for one inference: config-bus write decode, encoder words read by beat index,
// decoder rows and all biases presented in parallel.
module vae_param_regfile
    import vae_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [7:0]                  addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [ENC_IDX_W-1:0]        enc_idx,
    output logic [DATA_WIDTH-1:0]       xj,
    output logic [DATA_WIDTH-1:0]       mean_w1,
    output logic [DATA_WIDTH-1:0]       mean_w2,
    output logic [DATA_WIDTH-1:0]       var_w1,
    output logic [DATA_WIDTH-1:0]       var_w2,
    output logic [DATA_WIDTH-1:0]       mean_b1,
    output logic [DATA_WIDTH-1:0]       mean_b2,
    output logic [DATA_WIDTH-1:0]       var_b1,
    output logic [DATA_WIDTH-1:0]       var_b2,
    output logic [N_OUT*DATA_WIDTH-1:0] dec_row0,
    output logic [N_OUT*DATA_WIDTH-1:0] dec_row1,
    output logic [N_OUT*DATA_WIDTH-1:0] dec_bias
);
    localparam logic [ENC_IDX_W-1:0] ENC_LIM = ENC_IDX_W'(N_IN);

    logic [DATA_WIDTH-1:0] x_reg   [N_IN];
    logic [DATA_WIDTH-1:0] mw1_reg [N_IN];
    logic [DATA_WIDTH-1:0] mw2_reg [N_IN];
    logic [DATA_WIDTH-1:0] vw1_reg [N_IN];
    logic [DATA_WIDTH-1:0] vw2_reg [N_IN];
    logic [DATA_WIDTH-1:0] eb_reg  [N_ENC_B];
    logic [DATA_WIDTH-1:0] d0_reg  [N_OUT];
    logic [DATA_WIDTH-1:0] d1_reg  [N_OUT];
    logic [DATA_WIDTH-1:0] db_reg  [N_OUT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_IN; k++) begin
                x_reg[k]   <= '0;
                mw1_reg[k] <= '0;
                mw2_reg[k] <= '0;
                vw1_reg[k] <= '0;
                vw2_reg[k] <= '0;
            end
            for (int k = 0; k < N_ENC_B; k++) eb_reg[k] <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                d0_reg[k] <= '0;
                d1_reg[k] <= '0;
                db_reg[k] <= '0;
            end
        end else if (we) begin
            // Unmapped addresses match no entry and fall through untouched.
            for (int k = 0; k < N_IN; k++) begin
                if (addr_hit(addr, XJ_BASE,  k)) x_reg[k]   <= wdata;
                if (addr_hit(addr, MW1_BASE, k)) mw1_reg[k] <= wdata;
                if (addr_hit(addr, MW2_BASE, k)) mw2_reg[k] <= wdata;
                if (addr_hit(addr, VW1_BASE, k)) vw1_reg[k] <= wdata;
                if (addr_hit(addr, VW2_BASE, k)) vw2_reg[k] <= wdata;
            end
            for (int k = 0; k < N_ENC_B; k++) begin
                if (addr_hit(addr, EB_BASE, k)) eb_reg[k] <= wdata;
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (addr_hit(addr, D0_BASE, k)) d0_reg[k] <= wdata;
                if (addr_hit(addr, D1_BASE, k)) d1_reg[k] <= wdata;
                if (addr_hit(addr, DB_BASE, k)) db_reg[k] <= wdata;
            end
        end
    end

    assign xj      = (enc_idx < ENC_LIM) ? x_reg[enc_idx]   : '0;
    assign mean_w1 = (enc_idx < ENC_LIM) ? mw1_reg[enc_idx] : '0;
    assign mean_w2 = (enc_idx < ENC_LIM) ? mw2_reg[enc_idx] : '0;
    assign var_w1  = (enc_idx < ENC_LIM) ? vw1_reg[enc_idx] : '0;
    assign var_w2  = (enc_idx < ENC_LIM) ? vw2_reg[enc_idx] : '0;

    assign mean_b1 = eb_reg[0];
    assign mean_b2 = eb_reg[1];
    assign var_b1  = eb_reg[2];
    assign var_b2  = eb_reg[3];

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
        assign dec_row0[gi*DATA_WIDTH +: DATA_WIDTH] = d0_reg[gi];
        assign dec_row1[gi*DATA_WIDTH +: DATA_WIDTH] = d1_reg[gi];
        assign dec_bias[gi*DATA_WIDTH +: DATA_WIDTH] = db_reg[gi];
    end
endmodule

// File: rtl/vae_param_streamer.sv
// Plays one inference's parameters into top_forward_vae on its fixed beat schedule, then waits
// for done (bounded by TIMEOUT) and captures the nine a3 results.
module vae_param_streamer
    import vae_pkg::*;
#(
    parameter int DEC_OFFSET = 25,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [7:0]                  cfg_addr,
    input  logic [DATA_WIDTH-1:0]       cfg_wdata,
    input  logic                        go,
    output logic                        busy,
    vae_param_streamer_if.master        vae,
    output logic [N_OUT*DATA_WIDTH-1:0] res_bus,
    output logic                        res_valid,
    output logic                        timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    // cnt_reg holds the cycle index (start beat = 0) of what the outputs currently show.
    localparam logic [CW-1:0] ENC_LAST_C = CW'(N_IN - 1);
    localparam logic [CW-1:0] ROW0_PREV_C = CW'(DEC_OFFSET - 1);
    localparam logic [CW-1:0] ROW0_C     = CW'(DEC_OFFSET);
    localparam logic [CW-1:0] TMO_LAST_C = CW'(TIMEOUT - 1);

    state_t                      state_reg;
    logic [CW-1:0]               cnt_reg;
    logic                        busy_reg;
    logic                        start_reg;
    logic [DATA_WIDTH-1:0]       xj_reg, mw1_reg, mw2_reg, vw1_reg, vw2_reg;
    logic [N_OUT*DATA_WIDTH-1:0] w_bus_reg;
    logic [N_OUT*DATA_WIDTH-1:0] res_reg;
    logic                        res_valid_reg;
    logic                        timeout_reg;

    logic [CW-1:0]               cnt_inc;
    logic [ENC_IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]       rf_xj, rf_mw1, rf_mw2, rf_vw1, rf_vw2;
    logic [N_OUT*DATA_WIDTH-1:0] rf_row0, rf_row1;

    assign cnt_inc = cnt_reg + 1'b1;
    assign rd_idx  = (state_reg == ENC) ? cnt_inc[ENC_IDX_W-1:0] : '0;

    vae_param_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (cfg_we & ~busy_reg),
        .addr     (cfg_addr),
        .wdata    (cfg_wdata),
        .enc_idx  (rd_idx),
        .xj       (rf_xj),
        .mean_w1  (rf_mw1),
        .mean_w2  (rf_mw2),
        .var_w1   (rf_vw1),
        .var_w2   (rf_vw2),
        .mean_b1  (vae.nnl2_mean_b1),
        .mean_b2  (vae.nnl2_mean_b2),
        .var_b1   (vae.nnl2_var_b1),
        .var_b2   (vae.nnl2_var_b2),
        .dec_row0 (rf_row0),
        .dec_row1 (rf_row1),
        .dec_bias (vae.nnl3_b_bus)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            start_reg     <= 1'b0;
            xj_reg        <= '0;
            mw1_reg       <= '0;
            mw2_reg       <= '0;
            vw1_reg       <= '0;
            vw2_reg       <= '0;
            w_bus_reg     <= '0;
            res_reg       <= '0;
            res_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            // Beat outputs default to zero so nothing stale survives past its beat.
            start_reg     <= 1'b0;
            xj_reg        <= '0;
            mw1_reg       <= '0;
            mw2_reg       <= '0;
            vw1_reg       <= '0;
            vw2_reg       <= '0;
            w_bus_reg     <= '0;
            res_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (go) begin
                        state_reg   <= ENC;
                        busy_reg    <= 1'b1;
                        cnt_reg     <= '0;
                        timeout_reg <= 1'b0;
                        start_reg   <= 1'b1;
                        xj_reg      <= rf_xj;
                        mw1_reg     <= rf_mw1;
                        mw2_reg     <= rf_mw2;
                        vw1_reg     <= rf_vw1;
                        vw2_reg     <= rf_vw2;
                    end
                end
                ENC: begin
                    cnt_reg <= cnt_inc;
                    if (cnt_reg < ENC_LAST_C) begin
                        xj_reg  <= rf_xj;
                        mw1_reg <= rf_mw1;
                        mw2_reg <= rf_mw2;
                        vw1_reg <= rf_vw1;
                        vw2_reg <= rf_vw2;
                    end else if (cnt_reg == ROW0_PREV_C) begin
                        w_bus_reg <= rf_row0;
                        state_reg <= DEC;
                    end else begin
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    cnt_reg <= cnt_inc;
                    if (cnt_reg == ROW0_PREV_C) begin
                        w_bus_reg <= rf_row0;
                        state_reg <= DEC;
                    end
                end
                DEC: begin
                    cnt_reg <= cnt_inc;
                    if (cnt_reg == ROW0_C) w_bus_reg <= rf_row1;
                    else state_reg <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_inc;
                    if (vae.done) begin
                        res_reg       <= vae.a3_bus;
                        res_valid_reg <= 1'b1;
                        state_reg     <= CAP;
                    end else if (cnt_reg == TMO_LAST_C) begin
                        timeout_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                CAP: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy              = busy_reg;
    assign vae.start         = start_reg;
    assign vae.xj            = xj_reg;
    assign vae.nnl2_mean_w1j = mw1_reg;
    assign vae.nnl2_mean_w2j = mw2_reg;
    assign vae.nnl2_var_w1j  = vw1_reg;
    assign vae.nnl2_var_w2j  = vw2_reg;
    assign vae.nnl3_w_bus    = w_bus_reg;
    assign res_bus           = res_reg;
    assign res_valid         = res_valid_reg;
    assign timeout_err       = timeout_reg;
endmodule

// File: tb/tb_vae_param_streamer.sv
// Scoreboard bench: stimulus predicts beats/results from a flat address-indexed config model,
// an independent negedge monitor compares whatever the streamer presents.
module tb_vae_param_streamer;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_we = 1'b0;
    logic [7:0]   cfg_addr = '0;
    logic [15:0]  cfg_wdata = '0;
    logic         go = 1'b0;
    logic         busy;
    logic [143:0] res_bus;
    logic         res_valid;
    logic         timeout_err;

    vae_param_streamer_if vif();

    vae_param_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .go          (go),
        .busy        (busy),
        .vae         (vif),
        .res_bus     (res_bus),
        .res_valid   (res_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic         st;
        logic [15:0]  x, mw1, mw2, vw1, vw2;
        logic [143:0] w;
    } beat_t;

    typedef struct {
        int           cyc;
        bit           tmo;
        logic [143:0] data;
    } res_t;

    beat_t        beat_q[$];
    res_t         res_q[$];
    logic [15:0]  mem [256];
    logic [143:0] last_res = '0;
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    logic         tmo_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [143:0] row(input int base);
        logic [143:0] r;
        for (int k = 0; k < 9; k++) r[k*16 +: 16] = mem[base + k];
        return r;
    endfunction

    function automatic logic [143:0] rand144();
        logic [143:0] r;
        for (int k = 0; k < 9; k++) r[k*16 +: 16] = 16'($urandom);
        return r;
    endfunction

    // Monitor: compares beats, static biases and result/timeout events each cycle.
    beat_t mb;
    res_t  mr;
    always @(negedge clk) begin
        if (rst) begin
            while (beat_q.size() > 0 && beat_q[0].cyc < cyc) begin
                mb = beat_q.pop_front();
                check("beat_missed", 256'(cyc), 256'(mb.cyc));
            end
            if (beat_q.size() > 0 && beat_q[0].cyc == cyc) begin
                mb = beat_q.pop_front();
                check("beat", {vif.start, vif.xj, vif.nnl2_mean_w1j, vif.nnl2_mean_w2j,
                               vif.nnl2_var_w1j, vif.nnl2_var_w2j, vif.nnl3_w_bus},
                      {mb.st, mb.x, mb.mw1, mb.mw2, mb.vw1, mb.vw2, mb.w});
            end else begin
                check("no_beat", {vif.start, vif.xj, vif.nnl2_mean_w1j, vif.nnl2_mean_w2j,
                                  vif.nnl2_var_w1j, vif.nnl2_var_w2j, vif.nnl3_w_bus}, '0);
            end
            check("biases", {vif.nnl2_mean_b1, vif.nnl2_mean_b2, vif.nnl2_var_b1, vif.nnl2_var_b2,
                             vif.nnl3_b_bus},
                  {mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53], row(8'h80)});
            if (res_valid) begin
                if (res_q.size() == 0) check("res_unexpected", 1, 0);
                else begin
                    mr = res_q.pop_front();
                    check("res_kind", 0, 256'(mr.tmo));
                    check("res_cycle", 256'(cyc), 256'(mr.cyc));
                    check("res_data", res_bus, mr.data);
                end
            end
            if (timeout_err && !tmo_prev) begin
                if (res_q.size() == 0) check("tmo_unexpected", 1, 0);
                else begin
                    mr = res_q.pop_front();
                    check("tmo_kind", 1, 256'(mr.tmo));
                    check("tmo_cycle", 256'(cyc), 256'(mr.cyc));
                end
            end
            tmo_prev = timeout_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        @(posedge clk);
        mem[a] = d;
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic push_beats(input int c0);
        beat_t b;
        for (int j = 0; j < 9; j++) begin
            b.cyc = c0 + j; b.st = (j == 0);
            b.x = mem[j]; b.mw1 = mem[8'h10 + j]; b.mw2 = mem[8'h20 + j];
            b.vw1 = mem[8'h30 + j]; b.vw2 = mem[8'h40 + j]; b.w = '0;
            beat_q.push_back(b);
        end
        b.st = 1'b0; b.x = '0; b.mw1 = '0; b.mw2 = '0; b.vw1 = '0; b.vw2 = '0;
        b.cyc = c0 + 25; b.w = row(8'h60); beat_q.push_back(b);
        b.cyc = c0 + 26; b.w = row(8'h70); beat_q.push_back(b);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_beat"}, {vif.start, vif.xj, vif.nnl2_mean_w1j, vif.nnl2_mean_w2j,
                               vif.nnl2_var_w1j, vif.nnl2_var_w2j}, '0);
        check({tag, "_wbus"}, vif.nnl3_w_bus, '0);
        check({tag, "_bias"}, {vif.nnl2_mean_b1, vif.nnl2_mean_b2, vif.nnl2_var_b1,
                               vif.nnl2_var_b2, vif.nnl3_b_bus}, '0);
        check({tag, "_res"}, res_bus, '0);
        check({tag, "_flags"}, {busy, res_valid, timeout_err}, '0);
    endtask

    // done_off < 0: never answer (timeout expected). poke: go + cfg write during ENC.
    task automatic run_seq(input int done_off, input bit poke, input bit early,
                           input logic [143:0] a3);
        int c0, endc;
        res_t r;
        go = 1'b1;
        c0 = cyc + 1;
        push_beats(c0);
        if (done_off < 0) begin
            r.cyc = c0 + 64; r.tmo = 1'b1; r.data = '0;
            res_q.push_back(r);
        end
        tick();
        go = 1'b0;
        check("busy_start", 256'(busy), 1);
        check("tmo_cleared", 256'(timeout_err), 0);
        while (cyc < c0 + 2) tick();
        if (poke) begin
            go = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h00; cfg_wdata = 16'h1234;
            tick();
            go = 1'b0; cfg_we = 1'b0;
        end
        if (early) begin
            while (cyc < c0 + 20) tick();
            vif.done = 1'b1; vif.a3_bus = rand144();
            tick();
            vif.done = 1'b0;
        end
        if (done_off >= 0) begin
            while (cyc < c0 + done_off) tick();
            vif.done = 1'b1; vif.a3_bus = a3;
            r.cyc = c0 + done_off + 1; r.tmo = 1'b0; r.data = a3;
            res_q.push_back(r);
            last_res = a3;
            tick();
            vif.done = 1'b0;
            endc = c0 + done_off + 2;
        end else begin
            endc = c0 + 64;
        end
        while (cyc < endc) tick();
        check("busy_end", 256'(busy), 0);
        check("tmo_end", 256'(timeout_err), 256'(done_off < 0));
        check("res_held", res_bus, last_res);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=hang expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [143:0] lanes;
        int d;
        for (int a = 0; a < 256; a++) mem[a] = '0;
        vif.done = 1'b0;
        vif.a3_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        tick();
        check_zero("after_reset");

        for (int j = 0; j < 9; j++) cfg_write(8'(j), 16'h0400);
        cfg_write(8'h50, 16'hFD17);
        cfg_write(8'h10, 16'h0000);
        for (int i = 0; i < 9; i++) begin
            cfg_write(8'h60 + 8'(i), 16'h050E);
            cfg_write(8'h70 + 8'(i), 16'h0B2F);
        end
        for (int k = 0; k < 9; k++) lanes[k*16 +: 16] = 16'(k + 1);
        run_seq(40, 1'b0, 1'b0, lanes);
        run_seq(-1, 1'b0, 1'b0, '0);
        run_seq(35, 1'b1, 1'b1, rand144());
        run_seq(27, 1'b0, 1'b0, rand144());
        run_seq(63, 1'b0, 1'b0, rand144());

        repeat (8) begin
            repeat (25) cfg_write(8'($urandom_range(0, 8'h8F)), 16'($urandom));
            vif.done = 1'b1; vif.a3_bus = rand144();
            tick();
            vif.done = 1'b0;
            d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(27, 63));
            run_seq(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand144());
        end

        go = 1'b1;
        push_beats(cyc + 1);
        tick();
        go = 1'b0;
        repeat (15) tick();
        #2 rst = 1'b0;
        #1;
        check_zero("mid_reset");
        beat_q.delete();
        res_q.delete();
        for (int a = 0; a < 256; a++) mem[a] = '0;
        last_res = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_seq(30, 1'b0, 1'b0, rand144());

        repeat (3) tick();
        check("beat_q_empty", 256'(beat_q.size()), 0);
        check("res_q_empty", 256'(res_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
